// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out shifter with valid/ready load,
// one-word holding buffer, runtime bit order and programmable bit period.
module piso_serializer #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             msb_first,
    input  logic [DIV_W-1:0] div,
    output logic             q,
    output logic             q_valid,
    output logic             sof,
    output logic             eos,
    output logic             busy
);
    localparam int BW = $clog2(WIDTH);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d, hold_q, hold_d;
    logic             msb_q, msb_d, hold_msb_q, hold_msb_d;
    logic [DIV_W-1:0] div_q, div_d, hold_div_q, hold_div_d, per_q, per_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             hold_full_q, hold_full_d;
    logic             q_q, q_d, valid_q, valid_d, sof_q, sof_d, eos_q, eos_d, busy_q, busy_d;
    logic             accept, adv, last, take;

    assign load_ready = ena & ~hold_full_q;

    always_comb begin
        accept      = load_valid & load_ready;
        adv         = per_q == div_q;
        last        = (state_q == SHIFT) & adv & (bit_q == BW'(WIDTH - 1));
        take        = ((state_q == IDLE) & accept) | (last & (hold_full_q | accept));
        state_d     = state_q;
        sh_d        = sh_q;
        msb_d       = msb_q;
        div_d       = div_q;
        bit_d       = bit_q;
        per_d       = per_q;
        hold_d      = hold_q;
        hold_msb_d  = hold_msb_q;
        hold_div_d  = hold_div_q;
        hold_full_d = hold_full_q;
        // Hold buffer wins over a same-cycle accept; both cannot happen together
        if (take) begin
            sh_d        = hold_full_q ? hold_q : din;
            msb_d       = hold_full_q ? hold_msb_q : msb_first;
            div_d       = hold_full_q ? hold_div_q : div;
            bit_d       = '0;
            per_d       = '0;
            state_d     = SHIFT;
            hold_full_d = 1'b0;
        end else if (last) begin
            state_d = IDLE;
        end else if (state_q == SHIFT) begin
            per_d = adv ? '0 : per_q + DIV_W'(1);
            bit_d = adv ? bit_q + BW'(1) : bit_q;
            sh_d  = !adv ? sh_q : msb_q ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
        end
        if ((state_q == SHIFT) & accept & ~last) begin
            hold_d      = din;
            hold_msb_d  = msb_first;
            hold_div_d  = div;
            hold_full_d = 1'b1;
        end
        valid_d = state_d == SHIFT;
        q_d     = valid_d & (msb_d ? sh_d[WIDTH-1] : sh_d[0]);
        sof_d   = take;
        eos_d   = valid_d & (bit_d == BW'(WIDTH - 1)) & (per_d == div_d);
        busy_d  = valid_d | hold_full_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            msb_q       <= 1'b0;
            div_q       <= '0;
            bit_q       <= '0;
            per_q       <= '0;
            hold_q      <= '0;
            hold_msb_q  <= 1'b0;
            hold_div_q  <= '0;
            hold_full_q <= 1'b0;
            q_q         <= 1'b0;
            valid_q     <= 1'b0;
            sof_q       <= 1'b0;
            eos_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else if (ena) begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            msb_q       <= msb_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            per_q       <= per_d;
            hold_q      <= hold_d;
            hold_msb_q  <= hold_msb_d;
            hold_div_q  <= hold_div_d;
            hold_full_q <= hold_full_d;
            q_q         <= q_d;
            valid_q     <= valid_d;
            sof_q       <= sof_d;
            eos_q       <= eos_d;
            busy_q      <= busy_d;
        end
    end

    // Strobes are held with the frozen state, so masking keeps them one enabled cycle wide
    assign q       = q_q;
    assign q_valid = valid_q;
    assign sof     = sof_q & ena;
    assign eos     = eos_q & ena;
    assign busy    = busy_q;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of serial order, timing, hold buffer,
// enable freeze and asynchronous reset.
module tb_piso_serializer;
    logic       clk, rst, ena, load_valid, load_ready, msb_first;
    logic       q, q_valid, sof, eos, busy;
    logic [7:0] din, div;
    int         n_cmp, n_bad;

    piso_serializer #(.WIDTH(8), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .ena(ena), .din(din), .load_valid(load_valid),
        .load_ready(load_ready), .msb_first(msb_first), .div(div), .q(q),
        .q_valid(q_valid), .sof(sof), .eos(eos), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input string tag, input logic [7:0] d, input logic m, input logic [7:0] dv);
        din        = d;
        msb_first  = m;
        div        = dv;
        load_valid = 1'b1;
        #1;
        chk({tag, " ready c0"}, load_ready, 1);
        tick();
    endtask

    task automatic idle(input string tag);
        #1;
        chk({tag, " idle q_valid"}, q_valid, 0);
        chk({tag, " idle q"}, q, 0);
        chk({tag, " idle busy"}, busy, 0);
        chk({tag, " idle sof"}, sof, 0);
        chk({tag, " idle eos"}, eos, 0);
    endtask

    // Bit c-1 of each mask is the expected value during cycle c after the first accept
    task automatic run(input string tag, input logic [31:0] eq, input logic [31:0] sofm,
                       input logic [31:0] eosm, input logic [31:0] rdym, input int n,
                       input int ld_at, input logic [7:0] ld_din, input int off_lo, input int off_hi);
        for (int c = 1; c <= n; c++) begin
            ena        = !(c >= off_lo && c <= off_hi);
            load_valid = (c == ld_at);
            if (c == ld_at) din = ld_din;
            #1;
            chk($sformatf("%s q c%0d", tag, c), q, eq[c-1]);
            chk($sformatf("%s q_valid c%0d", tag, c), q_valid, 1);
            chk($sformatf("%s sof c%0d", tag, c), sof, sofm[c-1]);
            chk($sformatf("%s eos c%0d", tag, c), eos, eosm[c-1]);
            chk($sformatf("%s ready c%0d", tag, c), load_ready, rdym[c-1]);
            chk($sformatf("%s busy c%0d", tag, c), busy, 1);
            tick();
        end
        load_valid = 1'b0;
        ena        = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; ena = 1'b1; load_valid = 1'b0; msb_first = 1'b0; din = '0; div = '0;
        tick();
        tick();
        idle("reset");
        rst = 1'b0;
        #1;
        chk("reset ready", load_ready, 1);

        start("lsb", 8'h0F, 1'b0, 8'd0);
        run("lsb", 32'h0F, 32'h1, 32'h80, 32'hFF, 8, -1, 8'h00, 0, -1);
        idle("lsb");

        start("msb", 8'h0F, 1'b1, 8'd0);
        run("msb", 32'hF0, 32'h1, 32'h80, 32'hFF, 8, -1, 8'h00, 0, -1);
        idle("msb");

        start("div2", 8'h81, 1'b0, 8'd2);
        run("div2", 32'h00E00007, 32'h1, 32'h800000, 32'hFFFFFF, 24, -1, 8'h00, 0, -1);
        idle("div2");

        start("b2b", 8'hAA, 1'b0, 8'd0);
        run("b2b", 32'h55AA, 32'h0101, 32'h8080, 32'hFF01, 16, 1, 8'h55, 0, -1);
        idle("b2b");

        start("refill", 8'h0F, 1'b0, 8'd0);
        run("refill", 32'h3C0F, 32'h0101, 32'h8080, 32'hFFFF, 16, 8, 8'h3C, 0, -1);
        idle("refill");

        start("ena", 8'h0F, 1'b0, 8'd0);
        run("ena", 32'h01FF, 32'h1, 32'h1000, 32'h1F83, 13, -1, 8'h00, 3, 7);
        idle("ena");

        start("rst", 8'h0F, 1'b0, 8'd0);
        run("rst", 32'h7, 32'h1, 32'h0, 32'h7, 3, -1, 8'h00, 0, -1);
        rst = 1'b1;
        idle("rst async");
        tick();
        idle("rst held");
        rst = 1'b0;
        #1;
        chk("rst ready", load_ready, 1);
        start("post", 8'h35, 1'b1, 8'd0);
        run("post", 32'hAC, 32'h1, 32'h80, 32'hFF, 8, -1, 8'h00, 0, -1);
        idle("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
